// File: rtl/spi_reg_target.sv
// ---------------------------------------------------------------------------
// spi_reg_target
//   SPI mode-0 target that converts SPI frames into single-cycle accesses on
//   the register-bank application interface. Frame layout:
//     byte 0 : command  (bit 7 = 1 write, 0 read; bits 6:0 ignored)
//     byte 1 : address  (LSBs taken as the register address)
//     byte 2+: data     (address auto-increments for each further byte)
//   SCLK, CS_N and MOSI are oversampled in the clk domain, so sclk must run at
//   clk/8 or slower.
// ---------------------------------------------------------------------------
module spi_reg_target #(
    parameter int REG_W       = 8,   // fixed at 8: one SPI byte per register
    parameter int ADDR_W      = 8,   // must be <= 8
    parameter int SYNC_STAGES = 2    // synchroniser depth, >= 2
) (
    input  logic              clk,
    input  logic              rstb,
    // SPI pins
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              busy,
    // register-bank application interface
    output logic              wr_rdn,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    output logic              we,
    input  logic [REG_W-1:0]  rdata,
    input  logic              ack,
    input  logic              err,
    output logic              err_flag
);

    // -----------------------------------------------------------------------
    // Frame sequencer states
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // cs_n high, waiting for a frame
        ST_CMD  = 2'd1,   // shifting in the command byte
        ST_ADDR = 2'd2,   // shifting in the address byte
        ST_DATA = 2'd3    // data bytes until cs_n rises
    } state_t;

    // -----------------------------------------------------------------------
    // Synchroniser and edge-detect state
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_busy;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    // -----------------------------------------------------------------------
    // Frame sequencer state
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [2:0]         r_bit_cnt;    // bit index within the current byte
    logic [REG_W-2:0]   r_rx;         // first seven bits of the byte in flight
    logic [REG_W-1:0]   r_tx;         // read data being shifted out on miso
    logic               r_miso;
    logic               r_wr_rdn;
    logic [ADDR_W-1:0]  r_addr;
    logic [REG_W-1:0]   r_wdata;
    logic               r_we;
    logic               r_rd_load;    // capture rdata on the next clk
    logic               r_err_flag;

    logic [REG_W-1:0]   w_rx_byte;    // complete byte including current bit
    logic               w_byte_done;  // this sclk rise completes a byte

    // -----------------------------------------------------------------------
    // Bring the three asynchronous SPI pins into the clk domain.
    // -----------------------------------------------------------------------
    // NOTE: cs_n stages reset to 1 (the idle level) so leaving reset with the
    // target deselected produces neither a false frame start nor busy=1.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Remember the previous synchronised level for edge detection, and
    // register busy straight from the synchronised chip select.
    // -----------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_cs_d   <= w_cs_s;
            r_busy   <= ~w_cs_s;
        end
    end

    // One-cycle strobes derived from the synchronised levels.
    assign w_sclk_rise = w_sclk_s  & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
    assign w_cs_fall   = ~w_cs_s   &  r_cs_d;
    assign w_cs_rise   = w_cs_s    & ~r_cs_d;

    // mosi and sclk pass through equal-depth chains, so the mosi level seen
    // alongside the rise strobe is the bit the controller presented.
    assign w_rx_byte   = {r_rx, w_mosi_s};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);

    // -----------------------------------------------------------------------
    // Frame sequencer: byte assembly, bank handshake, read-data shifting.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_miso     <= 1'b0;
            r_wr_rdn   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_rd_load  <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            // Write handshake: we holds until the bank acks; the address
            // advances on the edge that retires the write, so it reads as
            // incremented from the following cycle. An in-flight write is
            // allowed to finish even if cs_n has risen meanwhile.
            if (r_we && ack) begin
                r_we   <= 1'b0;
                r_addr <= r_addr + ADDR_W'(1);
                if (err) begin
                    r_err_flag <= 1'b1;
                end
            end

            // Read capture: addr became valid last cycle and rdata is
            // combinational on it. No ack means no data, so send zeros.
            if (r_rd_load) begin
                r_rd_load <= 1'b0;
                if (ack) begin
                    r_tx <= rdata;
                end else begin
                    r_tx       <= '0;
                    r_err_flag <= 1'b1;
                end
            end

            if (w_cs_rise) begin
                // Deselect always wins, including over a coincident 8th rise:
                // the partial or just-completed byte is discarded.
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= 3'd0;
                        r_miso    <= 1'b0;
                        if (w_cs_fall) begin
                            r_state    <= ST_CMD;
                            r_rx       <= '0;
                            r_err_flag <= 1'b0;
                        end
                    end

                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_byte[REG_W-2:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_byte_done) begin
                            r_wr_rdn <= w_rx_byte[7];
                            r_state  <= ST_ADDR;
                        end
                    end

                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_byte[REG_W-2:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_byte_done) begin
                            r_addr  <= w_rx_byte[ADDR_W-1:0];
                            r_state <= ST_DATA;
                            if (!r_wr_rdn) begin
                                r_rd_load <= 1'b1;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_byte[REG_W-2:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_byte_done) begin
                            if (r_wr_rdn) begin
                                r_wdata <= w_rx_byte;
                                r_we    <= 1'b1;
                            end else begin
                                r_addr    <= r_addr + ADDR_W'(1);
                                r_rd_load <= 1'b1;
                            end
                        end
                        // Mode 0: present the next bit on each falling edge
                        // so it is stable at the controller's next rise. The
                        // first fall of a byte exposes bit 7 of fresh data.
                        if (w_sclk_fall && !r_wr_rdn) begin
                            r_miso <= r_tx[REG_W-1];
                            r_tx   <= {r_tx[REG_W-2:0], 1'b0};
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, all driven directly from flops
    // -----------------------------------------------------------------------
    assign miso     = r_miso;
    assign busy     = r_busy;
    assign wr_rdn   = r_wr_rdn;
    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign we       = r_we;
    assign err_flag = r_err_flag;

endmodule

// File: tb/tb_spi_reg_target.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_target
//   Directed bench for spi_reg_target. Drives SPI mode-0 frames with a
//   160 ns sclk period against a 10 ns clk, models a register bank that
//   always acks (with switchable ack/err), logs every accepted write and
//   compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_reg_target;

    localparam int HALF = 80;   // sclk half period in ns (sclk = clk/16)

    typedef logic [7:0] byte_arr_t [8];

    logic       clk;
    logic       rstb;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       busy;
    logic       wr_rdn;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic       ack;
    logic       err;
    logic       err_flag;

    int          n_cmp;
    int          n_fail;
    int          we_cycles;
    logic [15:0] wr_log[$];
    logic [7:0]  rx_buf[8];

    spi_reg_target #(
        .REG_W      (8),
        .ADDR_W     (8),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk     (clk),
        .rstb    (rstb),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .busy    (busy),
        .wr_rdn  (wr_rdn),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .ack     (ack),
        .err     (err),
        .err_flag(err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: register 0x83 holds 0x5A, every other address reads addr^0x3C.
    assign rdata = (addr == 8'h83) ? 8'h5A : (addr ^ 8'h3C);

    // Write monitor: counts strobe cycles and logs each accepted write.
    always @(posedge clk) begin
        if (we) begin
            we_cycles++;
            if (ack) begin
                wr_log.push_back({addr, wdata});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] log_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 16'hxxxx;
    endfunction

    task automatic clear_log();
        we_cycles = 0;
        wr_log.delete();
    endtask

    // One full byte, MSB first; miso is sampled just before each rise.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #(HALF);
            rx[i] = miso;
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    // The first n bits of a byte only.
    task automatic spi_bits(input logic [7:0] tx, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            #(HALF);
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(posedge clk);
        #2;
        cs_n = 1'b0;
    endtask

    task automatic cs_high();
        #(HALF);
        cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic send_bytes(input byte_arr_t tx, input int n);
        logic [7:0] r;
        for (int k = 0; k < n; k++) begin
            spi_byte(tx[k], r);
            rx_buf[k] = r;
        end
    endtask

    task automatic run_frame(input byte_arr_t tx, input int n);
        cs_low();
        send_bytes(tx, n);
        cs_high();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        we_cycles = 0;
        rstb      = 1'b0;
        sclk      = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        ack       = 1'b1;
        err       = 1'b0;

        // ---- 1: reset holds everything at zero while SPI pins toggle ----
        repeat (4) begin
            #40 sclk = 1'b1; mosi = ~mosi;
            #40 sclk = 1'b0;
        end
        #2;
        check("rst_miso",     32'(miso),      32'h0);
        check("rst_busy",     32'(busy),      32'h0);
        check("rst_wr_rdn",   32'(wr_rdn),    32'h0);
        check("rst_addr",     32'(addr),      32'h0);
        check("rst_wdata",    32'(wdata),     32'h0);
        check("rst_err_flag", 32'(err_flag),  32'h0);
        check("rst_we_count", 32'(we_cycles), 32'h0);
        rstb = 1'b1;
        #100;

        // ---- 2: single write 0x80,0x03,0xA5 ----
        clear_log();
        cs_low();
        #(HALF);
        check("wr_busy_in_frame", 32'(busy), 32'h1);
        send_bytes('{8'h80, 8'h03, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        cs_high();
        check("wr_busy_after",  32'(busy),            32'h0);
        check("wr_we_cycles",   32'(we_cycles),       32'd1);
        check("wr_log0",        32'(log_at(0)),       32'h03A5);
        check("wr_wr_rdn",      32'(wr_rdn),          32'h1);
        check("wr_wdata",       32'(wdata),           32'hA5);
        check("wr_addr_inc",    32'(addr),            32'h04);

        // ---- 3: read 0x00,0x83 then two data bytes ----
        clear_log();
        run_frame('{8'h00, 8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        check("rd_miso_cmd",    32'(rx_buf[0]),  32'h00);
        check("rd_miso_addr",   32'(rx_buf[1]),  32'h00);
        check("rd_data_83",     32'(rx_buf[2]),  32'h5A);
        check("rd_data_84",     32'(rx_buf[3]),  32'hB8);
        check("rd_no_we",       32'(we_cycles),  32'd0);
        check("rd_wr_rdn",      32'(wr_rdn),     32'h0);
        check("rd_addr_final",  32'(addr),       32'h85);
        check("rd_err_flag",    32'(err_flag),   32'h0);
        check("rd_miso_idle",   32'(miso),       32'h0);

        // ---- 3b: read without ack -> zeros and sticky err_flag ----
        ack = 1'b0;
        run_frame('{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        ack = 1'b1;
        check("noack_data",     32'(rx_buf[2]),  32'h00);
        check("noack_err_flag", 32'(err_flag),   32'h1);

        // ---- 3c: err_flag clears at frame start; write with err sets it ----
        clear_log();
        err = 1'b1;
        cs_low();
        #(HALF);
        check("err_clr_at_start", 32'(err_flag), 32'h0);
        send_bytes('{8'h80, 8'h60, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        cs_high();
        err = 1'b0;
        check("err_wr_flag",    32'(err_flag),   32'h1);
        check("err_wr_log0",    32'(log_at(0)),  32'h605C);

        // ---- 4: burst write wrapping FF -> 00 ----
        clear_log();
        run_frame('{8'h80, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00}, 5);
        check("burst_count",    32'(wr_log.size()), 32'd3);
        check("burst_log0",     32'(log_at(0)),     32'hFE11);
        check("burst_log1",     32'(log_at(1)),     32'hFF22);
        check("burst_log2",     32'(log_at(2)),     32'h0033);
        check("burst_addr",     32'(addr),          32'h01);

        // ---- 5: abort after 4 data bits, then a full frame ----
        clear_log();
        cs_low();
        send_bytes('{8'h80, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        spi_bits(8'hF0, 4);
        cs_high();
        check("abort_no_we",    32'(we_cycles), 32'd0);
        run_frame('{8'h80, 8'h20, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        check("after_abort_cnt",  32'(we_cycles), 32'd1);
        check("after_abort_log0", 32'(log_at(0)), 32'h20C3);

        // ---- 5b: cs_n rise coincident with the 8th data rise ----
        clear_log();
        cs_low();
        send_bytes('{8'h80, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        spi_bits(8'h99, 7);
        mosi = 1'b1;
        #(HALF);
        sclk = 1'b1;
        cs_n = 1'b1;
        #(HALF);
        sclk = 1'b0;
        #(4 * HALF);
        check("cs_wins_no_we",  32'(we_cycles), 32'd0);
        check("cs_wins_wdata",  32'(wdata),     32'hC3);

        // ---- 6: reset in the middle of a data byte ----
        clear_log();
        cs_low();
        send_bytes('{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        spi_bits(8'hAA, 4);
        rstb = 1'b0;
        #1;
        check("midrst_wr_rdn",   32'(wr_rdn),   32'h0);
        check("midrst_addr",     32'(addr),     32'h00);
        check("midrst_wdata",    32'(wdata),    32'h00);
        check("midrst_busy",     32'(busy),     32'h0);
        check("midrst_we",       32'(we),       32'h0);
        check("midrst_miso",     32'(miso),     32'h0);
        cs_n = 1'b1;
        sclk = 1'b0;
        #99;
        rstb = 1'b1;
        #100;
        run_frame('{8'h80, 8'h41, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        check("postrst_count",  32'(we_cycles), 32'd1);
        check("postrst_log0",   32'(log_at(0)), 32'h4177);
        check("postrst_wr_rdn", 32'(wr_rdn),    32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
